// File: rtl/eth_mdio_ctrl.sv
// eth_mdio_ctrl: Clause-22 MDIO master with PHY reset sequencing.
// It holds eth_rstn low, then waits for the PHY to settle, then runs one
// 64-bit read or write frame on MDC/MDIO for each accepted request.
module eth_mdio_ctrl #(
   parameter int unsigned MDC_DIV         = 50,
   parameter int unsigned RST_CYCLES      = 1_000_000,
   parameter int unsigned POST_RST_CYCLES = 200_000
) (
   input  logic        CLK100MHZ,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [15:0] rdata,
   output logic        rd_err,
   output logic        eth_rstn,
   output logic        eth_mdc,
   output logic        eth_mdio_o,
   output logic        eth_mdio_oe,
   input  logic        eth_mdio_i
);

   localparam int unsigned DIV_W   = $clog2(2 * MDC_DIV);
   localparam int unsigned CNT_MAX = (RST_CYCLES > POST_RST_CYCLES) ? RST_CYCLES : POST_RST_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * MDC_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(MDC_DIV);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_RST_CYCLES - 1);

   // Frame bit indices (bit 0 is the first preamble bit on the wire)
   localparam logic [5:0] BIT_OE_OFF = 6'd46;
   localparam logic [5:0] BIT_TA     = 6'd47;
   localparam logic [5:0] BIT_DATA   = 6'd48;
   localparam logic [5:0] BIT_LAST   = 6'd63;

   localparam logic [1:0] S_RST_HOLD = 2'd0;
   localparam logic [1:0] S_RST_WAIT = 2'd1;
   localparam logic [1:0] S_IDLE     = 2'd2;
   localparam logic [1:0] S_SHIFT    = 2'd3;

   logic [1:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [5:0]       bit_q,     bit_d;
   logic [63:0]      frame_q,   frame_d;
   logic             we_q,      we_d;
   logic [15:0]      rx_q,      rx_d;
   logic             ta_err_q,  ta_err_d;
   logic [1:0]       sync_q,    sync_d;
   logic [15:0]      rdata_q,   rdata_d;
   logic             rd_err_q,  rd_err_d;
   logic             eth_rstn_q, eth_rstn_d;
   logic             eth_mdc_q,  eth_mdc_d;
   logic             mdio_o_q,   mdio_o_d;
   logic             mdio_oe_q,  mdio_oe_d;
   logic             ready_q,    ready_d;
   logic             done_q,     done_d;

   // Next-state and registered-output computation for the reset sequence and frame shifter
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_cnt_d  = div_cnt_q;
      bit_d      = bit_q;
      frame_d    = frame_q;
      we_d       = we_q;
      rx_d       = rx_q;
      ta_err_d   = ta_err_q;
      rdata_d    = rdata_q;
      rd_err_d   = rd_err_q;
      sync_d     = {sync_q[0], eth_mdio_i};
      eth_rstn_d = eth_rstn_q;
      eth_mdc_d  = 1'b0;
      mdio_o_d   = 1'b1;
      mdio_oe_d  = 1'b0;
      ready_d    = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         S_RST_HOLD: begin
            eth_rstn_d = 1'b0;
            if (cnt_q == RST_LAST) begin
               state_d    = S_RST_WAIT;
               cnt_d      = '0;
               eth_rstn_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_RST_WAIT: begin
            eth_rstn_d = 1'b1;
            if (cnt_q == POST_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_IDLE: begin
            ready_d = 1'b1;
            if (req) begin
               state_d   = S_SHIFT;
               ready_d   = 1'b0;
               we_d      = we;
               ta_err_d  = 1'b0;
               div_cnt_d = '0;
               bit_d     = '0;
               // Read frames keep the line high where the PHY owns it
               frame_d   = we ? {32'hFFFF_FFFF, 2'b01, 2'b01, phy_addr, reg_addr, 2'b10, wdata}
                              : {32'hFFFF_FFFF, 2'b01, 2'b10, phy_addr, reg_addr, 2'b11, 16'hFFFF};
               mdio_o_d  = frame_d[63];
               mdio_oe_d = 1'b1;
            end
         end

         S_SHIFT: begin
            mdio_o_d = mdio_o_q;
            if (div_cnt_q == DIV_LAST) begin
               // Sample at the end of the MDC-high phase
               if (!we_q) begin
                  if (bit_q == BIT_TA) begin
                     ta_err_d = sync_q[1];
                  end
                  if (bit_q >= BIT_DATA) begin
                     rx_d = {rx_q[14:0], sync_q[1]};
                  end
               end
               if (bit_q == BIT_LAST) begin
                  state_d   = S_IDLE;
                  ready_d   = 1'b1;
                  done_d    = 1'b1;
                  mdio_o_d  = 1'b1;
                  div_cnt_d = '0;
                  bit_d     = '0;
                  if (we_q) begin
                     rd_err_d = 1'b0;
                  end else begin
                     rdata_d  = rx_d;
                     rd_err_d = ta_err_d;
                  end
               end else begin
                  div_cnt_d = '0;
                  bit_d     = bit_q + 6'd1;
                  frame_d   = {frame_q[62:0], 1'b1};
                  mdio_o_d  = frame_d[63];
                  mdio_oe_d = we_q | (bit_d < BIT_OE_OFF);
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
               eth_mdc_d = (div_cnt_d >= DIV_HALF);
               mdio_oe_d = mdio_oe_q;
            end
         end

         default: begin
            state_d = S_RST_HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         state_q    <= S_RST_HOLD;
         cnt_q      <= '0;
         div_cnt_q  <= '0;
         bit_q      <= '0;
         frame_q    <= '1;
         we_q       <= 1'b0;
         rx_q       <= '0;
         ta_err_q   <= 1'b0;
         sync_q     <= 2'b11;
         rdata_q    <= '0;
         rd_err_q   <= 1'b0;
         eth_rstn_q <= 1'b0;
         eth_mdc_q  <= 1'b0;
         mdio_o_q   <= 1'b1;
         mdio_oe_q  <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_cnt_q  <= div_cnt_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
         we_q       <= we_d;
         rx_q       <= rx_d;
         ta_err_q   <= ta_err_d;
         sync_q     <= sync_d;
         rdata_q    <= rdata_d;
         rd_err_q   <= rd_err_d;
         eth_rstn_q <= eth_rstn_d;
         eth_mdc_q  <= eth_mdc_d;
         mdio_o_q   <= mdio_o_d;
         mdio_oe_q  <= mdio_oe_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign ready       = ready_q;
   assign done        = done_q;
   assign rdata       = rdata_q;
   assign rd_err      = rd_err_q;
   assign eth_rstn    = eth_rstn_q;
   assign eth_mdc     = eth_mdc_q;
   assign eth_mdio_o  = mdio_o_q;
   assign eth_mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// tb_eth_mdio_ctrl: scoreboard bench for eth_mdio_ctrl with a simple PHY model.
module tb_eth_mdio_ctrl;

   localparam int unsigned MDC_DIV   = 4;
   localparam int unsigned RST_CYC   = 20;
   localparam int unsigned POST_CYC  = 10;
   localparam int          FRAME_CYC = 128 * MDC_DIV;

   typedef struct {
      logic [63:0] frame;
      logic [63:0] mask;
      logic [63:0] oe;
      logic [15:0] rdata;
      logic        rd_err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  phy_addr = '0;
   logic [4:0]  reg_addr = '0;
   logic [15:0] wdata = '0;
   logic        eth_mdio_i = 1'b1;
   logic        ready, done, rd_err, eth_rstn, eth_mdc, eth_mdio_o, eth_mdio_oe;
   logic [15:0] rdata;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];

   logic        phy_present = 1'b0;
   logic [15:0] phy_data = '0;
   logic [15:0] model_rdata = '0;

   int          mon_cnt = 0;
   logic        mdc_prev = 1'b0;
   logic [63:0] cap = '0, cap_oe = '0, last_frame = '0, last_oe = '0;

   always #5 clk = ~clk;

   eth_mdio_ctrl #(
      .MDC_DIV(MDC_DIV),
      .RST_CYCLES(RST_CYC),
      .POST_RST_CYCLES(POST_CYC)
   ) dut (
      .CLK100MHZ(clk),
      .rst(rst),
      .req(req),
      .we(we),
      .phy_addr(phy_addr),
      .reg_addr(reg_addr),
      .wdata(wdata),
      .ready(ready),
      .done(done),
      .rdata(rdata),
      .rd_err(rd_err),
      .eth_rstn(eth_rstn),
      .eth_mdc(eth_mdc),
      .eth_mdio_o(eth_mdio_o),
      .eth_mdio_oe(eth_mdio_oe),
      .eth_mdio_i(eth_mdio_i)
   );

   // Bus monitor and PHY model: capture line state on each MDC rise, drive TA/DATA of reads
   always @(negedge clk) begin
      if (rst) begin
         mon_cnt    = 0;
         eth_mdio_i = 1'b1;
      end else if (eth_mdc && !mdc_prev) begin
         cap[63 - mon_cnt]    = eth_mdio_o;
         cap_oe[63 - mon_cnt] = eth_mdio_oe;
         if (phy_present && mon_cnt >= 46) begin
            if (mon_cnt == 46)      eth_mdio_i = 1'b1;
            else if (mon_cnt == 47) eth_mdio_i = 1'b0;
            else                    eth_mdio_i = phy_data[63 - mon_cnt];
         end else begin
            eth_mdio_i = 1'b1;
         end
         if (mon_cnt == 63) begin
            last_frame = cap;
            last_oe    = cap_oe;
            mon_cnt    = 0;
         end else begin
            mon_cnt++;
         end
      end
      mdc_prev = eth_mdc;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic w, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
      exp_t e;
      if (w) begin
         e.frame  = {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
         e.mask   = 64'hFFFF_FFFF_FFFF_FFFF;
         e.oe     = 64'hFFFF_FFFF_FFFF_FFFF;
         e.rdata  = model_rdata;
         e.rd_err = 1'b0;
      end else begin
         e.frame  = {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 18'h0};
         e.mask   = 64'hFFFF_FFFF_FFFC_0000;
         e.oe     = 64'hFFFF_FFFF_FFFC_0000;
         e.rdata  = phy_present ? phy_data : 16'hFFFF;
         e.rd_err = !phy_present;
         model_rdata = e.rdata;
      end
      sb.push_back(e);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
      end
   endtask

   // Issue one request; the edge after this call's setup is the acceptance edge
   task automatic start_txn(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input bit expect_done);
      wait_ready();
      we = w; phy_addr = pa; reg_addr = ra; wdata = wd; req = 1'b1;
      if (expect_done) push_exp(w, pa, ra, wd);
      tick();
      req = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int first_rise);
      cyc = 0;
      first_rise = -1;
      do begin
         tick();
         cyc++;
         if (eth_mdc === 1'b1 && first_rise < 0) first_rise = cyc;
      end while (done !== 1'b1 && cyc < FRAME_CYC + 100);
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", cyc);
      end
   endtask

   // Scoreboard consumer: called in the cycle where done is observed
   task automatic sb_pop_compare(input string name);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s sb_empty: done seen with no expected transaction", name);
         return;
      end
      e = sb.pop_front();
      checks++;
      if ((last_frame & e.mask) !== (e.frame & e.mask)) begin
         errors++;
         $display("FAIL %s frame: got %h required %h (mask %h)", name, last_frame, e.frame, e.mask);
      end
      checks++;
      if (last_oe !== e.oe) begin
         errors++;
         $display("FAIL %s oe_pattern: got %h required %h", name, last_oe, e.oe);
      end
      checks++;
      if (rdata !== e.rdata) begin
         errors++;
         $display("FAIL %s rdata: got %h required %h", name, rdata, e.rdata);
      end
      checks++;
      if (rd_err !== e.rd_err) begin
         errors++;
         $display("FAIL %s rd_err: got %b required %b", name, rd_err, e.rd_err);
      end
      checks++;
      if ({ready, eth_mdc, eth_mdio_oe, eth_mdio_o} !== 4'b1001) begin
         errors++;
         $display("FAIL %s done_cycle_lines: ready/mdc/oe/o got %b required 1001",
                  name, {ready, eth_mdc, eth_mdio_oe, eth_mdio_o});
      end
   endtask

   // Follows the reset sequence from the first edge after rst is released
   task automatic check_reset_sequence(input string name);
      for (int k = 1; k <= int'(RST_CYC + POST_CYC) + 5; k++) begin
         tick();
         checks++;
         if (eth_rstn !== (k >= int'(RST_CYC))) begin
            errors++;
            $display("FAIL %s eth_rstn@%0d: got %b required %b", name, k, eth_rstn, (k >= int'(RST_CYC)));
         end
         checks++;
         if (ready !== (k >= int'(RST_CYC + POST_CYC))) begin
            errors++;
            $display("FAIL %s ready@%0d: got %b required %b", name, k, ready, (k >= int'(RST_CYC + POST_CYC)));
         end
         checks++;
         if ({eth_mdc, eth_mdio_oe, done} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle_lines@%0d: mdc/oe/done got %b required 000", name, k,
                     {eth_mdc, eth_mdio_oe, done});
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({eth_rstn, eth_mdc, eth_mdio_o, eth_mdio_oe, ready, done, rd_err} !== 7'b0010000) begin
         errors++;
         $display("FAIL reset_values: rstn/mdc/o/oe/ready/done/rd_err got %b required 0010000",
                  {eth_rstn, eth_mdc, eth_mdio_o, eth_mdio_oe, ready, done, rd_err});
      end
      checks++;
      if (rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rdata: got %h required 0000", rdata);
      end
      rst = 1'b0;
      check_reset_sequence("reset_seq");
   endtask

   task automatic test_write();
      int cyc, fr;
      start_txn(1'b1, 5'h01, 5'h00, 16'h3100, 1'b1);
      wait_done(cyc, fr);
      checks++;
      if (cyc !== FRAME_CYC) begin
         errors++;
         $display("FAIL write_latency: done after %0d edges, required %0d", cyc, FRAME_CYC);
      end
      checks++;
      if (fr !== int'(MDC_DIV)) begin
         errors++;
         $display("FAIL write_first_mdc: first rise after %0d edges, required %0d", fr, MDC_DIV);
      end
      sb_pop_compare("write");
   endtask

   task automatic test_read();
      int cyc, fr;
      phy_present = 1'b1;
      phy_data    = 16'h1234;
      start_txn(1'b0, 5'h01, 5'h02, 16'h0000, 1'b1);
      wait_done(cyc, fr);
      checks++;
      if (cyc !== FRAME_CYC) begin
         errors++;
         $display("FAIL read_latency: done after %0d edges, required %0d", cyc, FRAME_CYC);
      end
      sb_pop_compare("read");
   endtask

   task automatic test_no_phy();
      int cyc, fr;
      phy_present = 1'b0;
      start_txn(1'b0, 5'h1F, 5'h03, 16'h0000, 1'b1);
      wait_done(cyc, fr);
      sb_pop_compare("read_no_phy");
      start_txn(1'b1, 5'h01, 5'h04, 16'hA5A5, 1'b1);
      wait_done(cyc, fr);
      sb_pop_compare("write_after_err");
   endtask

   task automatic test_back_to_back();
      int cyc, fr, ndone;
      phy_present = 1'b1;
      phy_data    = 16'h8001;
      ndone = 0;
      start_txn(1'b1, 5'h03, 5'h11, 16'hC0DE, 1'b1);
      cyc = 0;
      while (cyc < FRAME_CYC + 100) begin
         if (cyc == 100) begin
            we = 1'b0; phy_addr = 5'h1E; reg_addr = 5'h1D; req = 1'b1;
         end else if (cyc == 101) begin
            req = 1'b0;
         end
         if (cyc == FRAME_CYC - 12) begin
            we = 1'b0; phy_addr = 5'h07; reg_addr = 5'h01; req = 1'b1;
            push_exp(1'b0, 5'h07, 5'h01, 16'h0000);
         end
         tick();
         cyc++;
         if (done === 1'b1) break;
      end
      if (done === 1'b1) ndone++;
      checks++;
      if (cyc !== FRAME_CYC) begin
         errors++;
         $display("FAIL b2b_first_latency: done after %0d edges, required %0d", cyc, FRAME_CYC);
      end
      sb_pop_compare("b2b_first");
      tick();
      req = 1'b0;
      wait_done(cyc, fr);
      if (done === 1'b1) ndone++;
      checks++;
      if (cyc !== FRAME_CYC) begin
         errors++;
         $display("FAIL b2b_second_latency: done after %0d edges, required %0d", cyc, FRAME_CYC);
      end
      sb_pop_compare("b2b_second");
      for (int k = 0; k < 60; k++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone !== 2) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d required 2", ndone);
      end
   endtask

   task automatic test_reset_mid_frame();
      int cyc, fr;
      phy_present = 1'b1;
      phy_data    = 16'h0F0F;
      start_txn(1'b0, 5'h01, 5'h01, 16'h0000, 1'b0);
      for (int k = 0; k < 40 * 2 * int'(MDC_DIV) + 2; k++) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({eth_mdio_oe, eth_rstn, ready, done, eth_mdc, eth_mdio_o} !== 6'b000001) begin
         errors++;
         $display("FAIL abort_lines: oe/rstn/ready/done/mdc/o got %b required 000001",
                  {eth_mdio_oe, eth_rstn, ready, done, eth_mdc, eth_mdio_o});
      end
      rst = 1'b0;
      check_reset_sequence("abort_seq");
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL abort_sb: %0d pending expectations, required 0", sb.size());
      end
      phy_data = 16'h5A5A;
      start_txn(1'b0, 5'h02, 5'h05, 16'h0000, 1'b1);
      wait_done(cyc, fr);
      sb_pop_compare("read_after_abort");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_no_phy();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
